// File: rtl/stage_mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM states,
// funct3 access-size/sign encodings and the opcodes the stage recognises.
package stage_mem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // funct3[1:0] access size (log2 bytes); funct3[2] selects zero-extension on loads
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int unsigned F3_UNSIGNED_BIT = 2;

  // Jumps never touch the data bus, whatever the enables say
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper shared by both directions: load extract/extend from the
// read bus, store lane replication and byte enables, alignment check.
// Access sizes above the datapath width clamp to full width.
module lsu_align
  import stage_mem_lsu_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 32
) (
  input  logic [2:0]                       funct3,
  input  logic [$clog2(REG_WIDTH/8)-1:0]   offset,
  input  logic [REG_WIDTH-1:0]             rdata,
  input  logic [REG_WIDTH-1:0]             wdata,
  output logic [REG_WIDTH-1:0]             load_data,
  output logic [REG_WIDTH-1:0]             wdata_rep,
  output logic [REG_WIDTH/8-1:0]           be,
  output logic [$clog2(REG_WIDTH/8)-1:0]   off_al,
  output logic                             misaligned
);

  localparam int unsigned NB = REG_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned IW = $clog2(REG_WIDTH);
  localparam logic [1:0]  MAX_SZ = 2'(OW);

  logic [1:0]           sz;
  logic [OW-1:0]        low_mask;
  logic [REG_WIDTH-1:0] shifted;
  logic [REG_WIDTH-1:0] keep_mask;
  logic [IW-1:0]        msb;
  logic                 sgn;

  // Size clamp, alignment, lane selection and sign/zero extension
  always_comb begin
    sz         = (funct3[1:0] > MAX_SZ) ? MAX_SZ : funct3[1:0];
    low_mask   = OW'((32'd1 << sz) - 32'd1);
    misaligned = |(offset & low_mask);
    off_al     = offset & ~low_mask;
    shifted    = rdata >> {off_al, 3'b000};
    msb        = IW'((32'd8 << sz) - 32'd1);
    keep_mask  = (sz == MAX_SZ) ? '1
                 : ((REG_WIDTH'(1) << (32'd8 << sz)) - REG_WIDTH'(1));
    sgn        = ~funct3[F3_UNSIGNED_BIT] & shifted[msb];
    load_data  = (shifted & keep_mask) | (sgn ? ~keep_mask : '0);
    be         = NB'((32'd1 << (32'd1 << sz)) - 32'd1) << off_al;
    case (sz)
      SZ_B:    wdata_rep = {NB{wdata[7:0]}};
      SZ_H:    wdata_rep = {(NB/2){wdata[15:0]}};
      SZ_W:    wdata_rep = {(NB/4){wdata[31:0]}};
      SZ_D:    wdata_rep = wdata;
      default: wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM pipeline stage: issues one data-bus access per load/store and stalls
// upstream until it completes; other instructions pass straight through.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned accesses trap (no bus
// access, misaligned pulse, zero result); otherwise they are aligned down.
module stage_mem_lsu
  import stage_mem_lsu_pkg::*;
#(
  parameter int unsigned REG_WIDTH       = 32,
  parameter int unsigned DMEM_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       EX_MEM_valid,
  input  logic                       EX_MEM_mem_read_en,
  input  logic                       EX_MEM_mem_write_en,
  input  logic [6:0]                 EX_MEM_inst_opcode,
  input  logic [2:0]                 EX_MEM_funct3,
  input  logic [REG_WIDTH-1:0]       EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]       EX_MEM_dataB,
  output logic [REG_WIDTH-1:0]       DMEM_data_out,
  output logic                       MEM_valid,
  output logic                       mem_stall,
  output logic                       misaligned,
  output logic                       dbus_req,
  output logic                       dbus_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dbus_addr,
  output logic [REG_WIDTH-1:0]       dbus_wdata,
  output logic [REG_WIDTH/8-1:0]     dbus_be,
  input  logic                       dbus_ack,
  input  logic [REG_WIDTH-1:0]       dbus_rdata
);

  localparam int unsigned NB = REG_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_e                 state_q, state_d;
  logic                       is_jump, memop, is_store, trap_c;
  logic                       go_req, go_trap, take_ack, mis_pulse, mis_c;
  logic [REG_WIDTH-1:0]       load_ext, wdata_rep, load_q;
  logic [NB-1:0]              be_c;
  logic [OW-1:0]              off_al;
  logic [DMEM_ADDR_WIDTH-1:0] addr_al;

  lsu_align #(.REG_WIDTH(REG_WIDTH)) u_align (
    .funct3     (EX_MEM_funct3),
    .offset     (EX_MEM_alu_out[OW-1:0]),
    .rdata      (dbus_rdata),
    .wdata      (EX_MEM_dataB),
    .load_data  (load_ext),
    .wdata_rep  (wdata_rep),
    .be         (be_c),
    .off_al     (off_al),
    .misaligned (mis_c)
  );

  // Decode the memop and form the size-aligned bus address
  always_comb begin
    is_jump  = (EX_MEM_inst_opcode == OPC_JAL) || (EX_MEM_inst_opcode == OPC_JALR);
    memop    = EX_MEM_valid & (EX_MEM_mem_read_en | EX_MEM_mem_write_en) & ~is_jump;
    is_store = EX_MEM_mem_write_en;
    trap_c   = TRAP_EN & mis_c;
    addr_al  = DMEM_ADDR_WIDTH'(EX_MEM_alu_out);
    addr_al[OW-1:0] = off_al;
  end

  // Misaligned pulse is held low while reset is asserted
  assign misaligned = mis_pulse & reset_n;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state, stall and stage result
  always_comb begin
    state_d       = state_q;
    go_req        = 1'b0;
    go_trap       = 1'b0;
    take_ack      = 1'b0;
    mis_pulse     = 1'b0;
    mem_stall     = 1'b0;
    MEM_valid     = 1'b0;
    DMEM_data_out = '0;
    case (state_q)
      ST_IDLE: begin
        DMEM_data_out = EX_MEM_alu_out;
        MEM_valid     = EX_MEM_valid & ~memop;
        if (memop) begin
          mem_stall = 1'b1;
          if (trap_c) begin
            state_d   = ST_RESP;
            go_trap   = 1'b1;
            mis_pulse = 1'b1;
          end else begin
            state_d = ST_REQ;
            go_req  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        mem_stall = 1'b1;
        if (dbus_ack) begin
          state_d  = ST_RESP;
          take_ack = 1'b1;
        end
      end
      ST_RESP: begin
        MEM_valid     = 1'b1;
        DMEM_data_out = load_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus request registers and captured load result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_be    <= '0;
      load_q     <= '0;
    end else begin
      if (go_req) begin
        dbus_req   <= 1'b1;
        dbus_we    <= is_store;
        dbus_addr  <= addr_al;
        dbus_wdata <= is_store ? wdata_rep : '0;
        dbus_be    <= be_c;
        load_q     <= '0;
      end
      if (go_trap) load_q <= '0;
      if (take_ack) begin
        dbus_req <= 1'b0;
        if (!dbus_we) load_q <= load_ext;
      end
    end
  end

endmodule
